// File: rtl/latch_write_arbiter_pkg.sv
// Shared definitions for latch-bank write controllers: FSM state codes.
package latch_write_arbiter_pkg;

  typedef logic [1:0] lwa_state_t;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_STROBE = 2'd2;
  localparam logic [1:0] ST_HOLD   = 2'd3;

endpackage

// File: rtl/latch_write_arbiter_if.sv
// Requester / latch-bank bundle for the latch write arbiter.
interface latch_write_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8
);

  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        gnt;
  logic [NUM_REQ-1:0]        ack;
  logic [DATA_W-1:0]         latch_d;
  logic                      latch_en;
  logic                      busy;

  // Requester side (drives requests, observes grants and the latch bank)
  modport master (
    output req, req_data,
    input  gnt, ack, latch_d, latch_en, busy
  );

  // Arbiter side
  modport slave (
    input  req, req_data,
    output gnt, ack, latch_d, latch_en, busy
  );

endinterface

// File: rtl/latch_write_arbiter_rr_priority_pick.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module rr_priority_pick
  import latch_write_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]         pick,
  output logic                       any
);

  // Scan NUM_REQ positions starting at ptr; the first hit wins
  always_comb begin
    pick = '0;
    any  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!any && req[(int'(ptr) + i) % NUM_REQ]) begin
        pick[(int'(ptr) + i) % NUM_REQ] = 1'b1;
        any                             = 1'b1;
      end
    end
  end

endmodule

// File: rtl/latch_write_arbiter.sv
// Round-robin arbiter sharing one bank of level-sensitive latches among
// NUM_REQ requesters. Each write runs IDLE -> SETUP -> STROBE -> HOLD so the
// latch data is stable before, during and after the enable pulse.
module latch_write_arbiter
  import latch_write_arbiter_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int DATA_W        = 8,
  parameter int STROBE_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  latch_write_arbiter_if.slave bus
);

  localparam int PW = $clog2(NUM_REQ);
  localparam int CW = $clog2(STROBE_CYCLES + 1);

  lwa_state_t          state_q, state_d;
  logic [PW-1:0]       ptr_q, ptr_d;
  logic [PW-1:0]       win_q, win_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic [NUM_REQ-1:0]  ack_q, ack_d;
  logic [DATA_W-1:0]   latch_d_q, latch_d_d;
  logic                latch_en_q, latch_en_d;
  logic                busy_q, busy_d;

  logic [NUM_REQ-1:0]  pick;
  logic                pick_any;
  logic [PW-1:0]       pick_idx;
  logic [DATA_W-1:0]   data_arr [NUM_REQ];

  rr_priority_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req  (bus.req),
    .ptr  (ptr_q),
    .pick (pick),
    .any  (pick_any)
  );

  // Encode the one-hot pick and split the flat data bus per requester
  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      data_arr[i] = bus.req_data[i*DATA_W +: DATA_W];
      if (pick[i]) pick_idx = PW'(i);
    end
  end

  // Write sequencer: latch_d only ever changes in IDLE, so it is frozen
  // from SETUP through HOLD and never moves while latch_en is high
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    win_d      = win_q;
    cnt_d      = cnt_q;
    gnt_d      = gnt_q;
    ack_d      = '0;
    latch_d_d  = latch_d_q;
    latch_en_d = latch_en_q;
    busy_d     = busy_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          state_d   = ST_SETUP;
          win_d     = pick_idx;
          latch_d_d = data_arr[pick_idx];
          gnt_d     = pick;
          busy_d    = 1'b1;
        end
      end
      ST_SETUP: begin
        state_d    = ST_STROBE;
        latch_en_d = 1'b1;
        cnt_d      = '0;
      end
      ST_STROBE: begin
        if (cnt_q == CW'(STROBE_CYCLES - 1)) begin
          state_d    = ST_HOLD;
          latch_en_d = 1'b0;
          ack_d      = gnt_q;
          cnt_d      = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
        busy_d  = 1'b0;
        ptr_d   = (win_q == PW'(NUM_REQ - 1)) ? '0 : win_q + 1'b1;
      end
    endcase
  end

  // State and registered outputs; reset drops the enable and grant at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      win_q      <= '0;
      cnt_q      <= '0;
      gnt_q      <= '0;
      ack_q      <= '0;
      latch_d_q  <= '0;
      latch_en_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      win_q      <= win_d;
      cnt_q      <= cnt_d;
      gnt_q      <= gnt_d;
      ack_q      <= ack_d;
      latch_d_q  <= latch_d_d;
      latch_en_q <= latch_en_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.gnt      = gnt_q;
  assign bus.ack      = ack_q;
  assign bus.latch_d  = latch_d_q;
  assign bus.latch_en = latch_en_q;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_latch_write_arbiter.sv
// Testbench for latch_write_arbiter: directed scenarios plus random traffic
// against a transaction-level model (write phase counter per arbitration).
module tb_latch_write_arbiter;

  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 8;
  localparam int S       = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  latch_write_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) bus ();

  latch_write_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .STROBE_CYCLES(S)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // model: one write in flight, m_k = cycles since its arbitration edge
  bit                m_act = 1'b0;
  int                m_k   = 0;
  int                m_w   = 0;
  int                m_ptr = 0;
  logic [DATA_W-1:0] m_ld  = '0;

  logic [DATA_W-1:0] bank    = '0;
  logic              prev_en = 1'b0;
  logic [DATA_W-1:0] prev_ld = '0;
  logic [NUM_REQ-1:0] prev_ack = '0;
  int  cyc       = 0;
  int  acked_now = -1;
  bit  auto_hs   = 1'b1;
  int  ack_idx[$];
  int  ack_cyc[$];

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  task automatic model_update();
    bit found;
    if (m_act) begin
      m_k++;
      if (m_k == S + 3) begin
        m_act = 1'b0;
        m_ptr = (m_w + 1) % NUM_REQ;
      end
    end else if (bus.req != '0) begin
      found = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!found && bus.req[(m_ptr + i) % NUM_REQ]) begin
          m_w   = (m_ptr + i) % NUM_REQ;
          found = 1'b1;
        end
      end
      m_act = 1'b1;
      m_k   = 1;
      m_ld  = bus.req_data[m_w*DATA_W +: DATA_W];
    end
  endtask

  task automatic check_outputs();
    logic [NUM_REQ-1:0] eg, ea;
    logic ee;
    eg = m_act ? NUM_REQ'(1 << m_w) : '0;
    ea = (m_act && m_k == S + 2) ? NUM_REQ'(1 << m_w) : '0;
    ee = m_act && m_k >= 2 && m_k <= S + 1;
    check_val("gnt", bus.gnt, eg);
    check_val("ack", bus.ack, ea);
    check_val("latch_en", bus.latch_en, ee);
    check_val("busy", bus.busy, m_act);
    check_val("latch_d", bus.latch_d, m_ld);
    check_val("gnt_onehot0", $onehot0(bus.gnt), 1);
    if (bus.latch_en && prev_en) check_val("latch_d_stable", bus.latch_d, prev_ld);
    if (prev_ack != '0) check_val("ack_single", bus.ack, 0);
    if (bus.latch_en) bank = bus.latch_d;
    if (ea != '0) check_val("bank", bank, m_ld);
    for (int i = 0; i < NUM_REQ; i++) begin
      if (bus.ack[i]) begin
        ack_idx.push_back(i);
        ack_cyc.push_back(cyc);
      end
    end
    prev_en  = bus.latch_en;
    prev_ld  = bus.latch_d;
    prev_ack = bus.ack;
    acked_now = -1;
    if (ea != '0 && auto_hs) begin
      bus.req[m_w] = 1'b0;
      acked_now = m_w;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    if (!rst) model_update();
    cyc++;
    @(negedge clk);
    check_outputs();
  endtask

  task automatic clear_log();
    ack_idx.delete();
    ack_cyc.delete();
  endtask

  task automatic run_until_acks(input int n, input int bound);
    for (int i = 0; i < bound; i++) begin
      if (ack_idx.size() >= n) break;
      cycle();
    end
    check_val("ack_count", ack_idx.size(), n);
  endtask

  task automatic model_reset();
    m_act = 1'b0; m_k = 0; m_ptr = 0; m_ld = '0;
    prev_en = 1'b0; prev_ack = '0; acked_now = -1;
  endtask

  task automatic apply_reset();
    bus.req = '0;
    bus.req_data = '0;
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_val("rst_gnt", bus.gnt, 0);
    check_val("rst_ack", bus.ack, 0);
    check_val("rst_latch_en", bus.latch_en, 0);
    check_val("rst_busy", bus.busy, 0);
    check_val("rst_latch_d", bus.latch_d, 0);
    rst = 1'b0;
    clear_log();
  endtask

  initial begin
    int c;
    bus.req = '0;
    bus.req_data = '0;

    // reset asserted in the middle of a strobe
    apply_reset();
    bus.req_data[2*DATA_W +: DATA_W] = 8'h3C;
    bus.req[2] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (m_act && m_k == 2) break;
      cycle();
    end
    check_val("pre_rst_latch_en", bus.latch_en, 1);
    #2 rst = 1'b1;
    #1;
    check_val("midrst_latch_en", bus.latch_en, 0);
    check_val("midrst_gnt", bus.gnt, 0);
    check_val("midrst_ack", bus.ack, 0);
    check_val("midrst_busy", bus.busy, 0);
    model_reset();
    @(negedge clk);
    bus.req[0] = 1'b1;
    bus.req_data[0 +: DATA_W] = 8'h11;
    rst = 1'b0;
    clear_log();
    run_until_acks(1, 15);
    if (ack_idx.size() > 0) check_val("rst_first_served", ack_idx[0], 0);

    // single write from requester 2
    apply_reset();
    bus.req_data[2*DATA_W +: DATA_W] = 8'hA5;
    bus.req[2] = 1'b1;
    c = cyc;
    run_until_acks(1, 12);
    if (ack_idx.size() > 0) begin
      check_val("single_ack_idx", ack_idx[0], 2);
      check_val("single_ack_cycle", ack_cyc[0], c + 4);
    end
    check_val("single_latch_d", bus.latch_d, 8'hA5);
    check_val("single_bank", bank, 8'hA5);

    // all four together: order 0..3, five-cycle spacing, pointer wraps
    apply_reset();
    for (int i = 0; i < NUM_REQ; i++) bus.req_data[i*DATA_W +: DATA_W] = DATA_W'(8'h10 + i);
    bus.req = '1;
    run_until_acks(4, 40);
    for (int i = 0; i < ack_idx.size(); i++) begin
      check_val("all_order", ack_idx[i], i);
      if (i > 0) check_val("all_spacing", ack_cyc[i] - ack_cyc[i-1], S + 3);
    end
    clear_log();
    bus.req = 4'b1001;
    run_until_acks(1, 15);
    if (ack_idx.size() > 0) check_val("wrap_first", ack_idx[0], 0);

    // requesters 1 and 3 held continuously after 1 is granted
    apply_reset();
    auto_hs = 1'b0;
    bus.req_data = 32'h44_00_22_00;
    bus.req = 4'b0010;
    cycle();
    bus.req = 4'b1010;
    run_until_acks(5, 60);
    if (ack_idx.size() >= 5) begin
      check_val("fair_0", ack_idx[1], 3);
      check_val("fair_1", ack_idx[2], 1);
      check_val("fair_2", ack_idx[3], 3);
      check_val("fair_3", ack_idx[4], 1);
    end
    auto_hs = 1'b1;

    // data changed after capture and req dropped while granted
    apply_reset();
    bus.req_data[1*DATA_W +: DATA_W] = 8'h5A;
    bus.req[1] = 1'b1;
    cycle();
    bus.req[1] = 1'b0;
    cycle();
    bus.req_data[1*DATA_W +: DATA_W] = 8'hFF;
    run_until_acks(1, 10);
    if (ack_idx.size() > 0) check_val("drop_ack_idx", ack_idx[0], 1);
    check_val("drop_latch_d", bus.latch_d, 8'h5A);
    check_val("drop_bank", bank, 8'h5A);

    // random traffic
    apply_reset();
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (i != acked_now && !bus.req[i] && $urandom_range(3) == 0) begin
          bus.req_data[i*DATA_W +: DATA_W] = DATA_W'($urandom);
          bus.req[i] = 1'b1;
        end
      end
      if (m_act && $urandom_range(7) == 0)
        bus.req_data[m_w*DATA_W +: DATA_W] = DATA_W'($urandom);
      if (m_act && m_k < S + 2 && $urandom_range(15) == 0)
        bus.req[m_w] = 1'b0;
      cycle();
    end
    check_val("rand_activity", ack_idx.size() > 20, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
